logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of each operand and of the result.
REQ-002 The block SHALL have parameter NUM_IN, default 2: operand count, legal range 2..8.
REQ-003 The block SHALL have parameter COUNT_W, default 16: width of the accepted-transaction counter.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept an input this cycle.
REQ-008 The block SHALL have port in_data, input, NUM_IN*WIDTH bits: operand k occupies bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port op, input, 3 bits: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 illegal.
REQ-010 The block SHALL have port out_valid, output, 1 bit: y and its flags hold a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port y, output, WIDTH bits: bitwise result across all NUM_IN operands.
REQ-013 The block SHALL have port y_any, output, 1 bit: OR-reduction of y.
REQ-014 The block SHALL have port y_all, output, 1 bit: AND-reduction of y.
REQ-015 The block SHALL have port err, output, 1 bit: sticky illegal-op flag.
REQ-016 The block SHALL have port count, output, COUNT_W bits: saturating count of accepted inputs.

Function
REQ-017 An input SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-018 in_ready SHALL be combinational: in_ready = !out_valid || out_ready.
REQ-019 y, y_any and y_all SHALL be registered and SHALL update on the accept edge, giving one-cycle latency; out_valid SHALL be 1 the following cycle.
REQ-020 The operation SHALL apply bitwise across all NUM_IN operands, with XOR giving per-bit odd parity and NAND/NOR/XNOR giving the inverse of AND/OR/XOR.
REQ-021 An illegal op SHALL still be accepted, SHALL produce y=0, y_any=0 and y_all=0, and SHALL set err.
REQ-022 err SHALL remain 1 until rst.
REQ-023 A result SHALL be held stable while out_valid && !out_ready.
REQ-024 A result SHALL be consumed when out_valid && out_ready.
REQ-025 On a cycle where a result is consumed and a new input is accepted, the register SHALL be replaced with no bubble and out_valid SHALL stay 1.
REQ-026 On a cycle where a result is consumed and no input is accepted, out_valid SHALL be 0 on the next cycle, with y retaining its last value.
REQ-027 count SHALL increment by 1 on each accept, including illegal-op accepts, and SHALL saturate at 2^COUNT_W-1 without wrapping.
REQ-028 in_data and op SHALL be ignored when no accept occurs.

Reset
REQ-029 rst SHALL be sampled only on the rising edge of clk.
REQ-030 While rst=1, out_valid, y, y_any, y_all, err and count SHALL all be 0 and no input SHALL be accepted.
REQ-031 While rst=1, in_ready SHALL be driven as 1.
REQ-032 rst asserted while a result is pending SHALL discard that result.
REQ-033 The first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-034 The macro LOGIC_GATE_UNIT_PARITY_EN SHALL control a parity output.
REQ-035 With LOGIC_GATE_UNIT_PARITY_EN defined, the block SHALL add output port y_par (1 bit), equal to the XOR-reduction of y, registered with y and reset to 0.
REQ-036 With LOGIC_GATE_UNIT_PARITY_EN undefined, port y_par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4, NUM_IN=2 unless stated)
REQ-037 The bench SHALL cover reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, y=0, err=0, count=0, in_ready=1, and no accept.
REQ-038 The bench SHALL cover OR: in_data=8'b0101_0011, op=1, out_ready=1 -> next cycle out_valid=1, y=4'b0111, y_any=1, y_all=0, count=1.
REQ-039 The bench SHALL cover the op sweep: operands 4'b0011/4'b0101 with op=0..5 -> y = 0001, 0111, 0110, 1110, 1000, 1001.
REQ-040 The bench SHALL cover backpressure: out_ready=0 with two inputs offered -> first held stable, in_ready=0, second accepted only on the cycle out_ready=1, and no loss or duplication.
REQ-041 The bench SHALL cover illegal op: op=7 -> y=0, err=1; err SHALL stay 1 after 3 further legal ops and clear only after rst.
REQ-042 The bench SHALL cover saturation and parity: with COUNT_W=4, 17 back-to-back accepts -> count=15; with LOGIC_GATE_UNIT_PARITY_EN defined and y=4'b0111 -> y_par=1.

Source files
------------

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: N-operand bitwise logic unit with a one-deep ready/valid
// output register, sticky illegal-op flag and saturating accept counter.
// Optional feature: define LOGIC_GATE_UNIT_PARITY_EN to add the registered
// y_par output (XOR-reduction of y).
module logic_gate_unit #(
  parameter int WIDTH   = 8,
  parameter int NUM_IN  = 2,
  parameter int COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    y_any,
  output logic                    y_all,
  output logic                    err,
  output logic [COUNT_W-1:0]      count
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  ,
  output logic                    y_par
`endif
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] result;
  logic             illegal;
  logic             accept;

  // Reset forces ready high so upstream sees a clean handshake, but nothing
  // is accepted until reset has been released.
  assign in_ready = rst || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !rst;

  // Bitwise reductions across all operands, then select by op.
  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_and = red_and & in_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
    end
    illegal = 1'b0;
    case (op)
      OP_AND:  result = red_and;
      OP_OR:   result = red_or;
      OP_XOR:  result = red_xor;
      OP_NAND: result = ~red_and;
      OP_NOR:  result = ~red_or;
      OP_XNOR: result = ~red_xor;
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Output register, handshake state, sticky error and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_any     <= 1'b0;
      y_all     <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        y         <= result;
        y_any     <= |result;
        y_all     <= &result;
        if (illegal) begin
          err <= 1'b1;
        end
        if (count != COUNT_MAX) begin
          count <= count + 1'b1;
        end
      end else if (out_ready) begin
        // Result consumed with nothing new: drop valid, keep y as it was.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_GATE_UNIT_PARITY_EN
  // Parity of the result, registered alongside y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par <= 1'b0;
    end else if (accept) begin
      y_par <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Testbench for logic_gate_unit (WIDTH=4, NUM_IN=2, COUNT_W=4).
// Directed scenarios plus random traffic checked against a per-bit
// "count the ones" reference model with a transaction-level output state.
// Optional feature macro: LOGIC_GATE_UNIT_PARITY_EN.
module tb_logic_gate_unit;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int CW = 4;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          y_any;
  logic          y_all;
  logic          err;
  logic [CW-1:0] count;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic          y_par;
`endif

  logic          m_valid;
  logic [W-1:0]  m_y;
  logic          m_err;
  int            m_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(W), .NUM_IN(N), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_any     (y_any),
    .y_all     (y_all),
    .err       (err),
    .count     (count)
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    ,
    .y_par     (y_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Per bit: count how many operands have a 1, then apply the gate rule.
  function automatic logic [W-1:0] ref_op(input logic [DW-1:0] d, input logic [2:0] o);
    logic [W-1:0] r;
    logic [DW-1:0] dd;
    r  = '0;
    dd = d;
    for (int b = 0; b < W; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(dd[k*W + b]);
      case (o)
        3'd0: r[b] = (ones == N);
        3'd1: r[b] = (ones > 0);
        3'd2: r[b] = (ones % 2 == 1);
        3'd3: r[b] = !(ones == N);
        3'd4: r[b] = !(ones > 0);
        3'd5: r[b] = !(ones % 2 == 1);
        default: r[b] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // One clock: drive at negedge, check in_ready, step model, check outputs.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [2:0] o,
                       input logic ordy, input logic r);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    op        = o;
    out_ready = ordy;
    rst       = r;
    #1;
    exp_rdy = r || !m_valid || ordy;
    acc     = v && exp_rdy && !r;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0;
      m_y     = '0;
      m_err   = 1'b0;
      m_count = 0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_y     = ref_op(d, o);
      if (o > 3'd5) m_err = 1'b1;
      if (m_count < (1 << CW) - 1) m_count++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("y", 32'(y), 32'(m_y));
    chk("y_any", 32'(y_any), 32'(m_y != 0));
    chk("y_all", 32'(y_all), 32'(m_y == '1));
    chk("err", 32'(err), 32'(m_err));
    chk("count", 32'(count), 32'(m_count));
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    chk("y_par", 32'(y_par), 32'(^m_y));
`endif
  endtask

  logic [W-1:0] sweep_exp [6];
  logic [DW-1:0] pat;

  initial begin
    sweep_exp = '{4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 4'b1001};
    pat       = 8'b0101_0011;
    m_valid   = 1'b0;
    m_y       = '0;
    m_err     = 1'b0;
    m_count   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    op        = '0;
    out_ready = 1'b1;

    // Reset held two cycles with valid input offered: nothing accepted.
    cycle(1'b1, pat, 3'd1, 1'b1, 1'b1);
    cycle(1'b1, pat, 3'd1, 1'b1, 1'b1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // OR, first accept right after reset release.
    cycle(1'b1, pat, 3'd1, 1'b1, 1'b0);
    chk("or_y", 32'(y), 32'h7);
    chk("or_any", 32'(y_any), 32'd1);
    chk("or_all", 32'(y_all), 32'd0);
    chk("or_count", 32'(count), 32'd1);

    // Op sweep, back-to-back.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, pat, 3'(i), 1'b1, 1'b0);
      chk($sformatf("sweep_op%0d", i), 32'(y), 32'(sweep_exp[i]));
    end
    cycle(1'b0, '0, 3'd0, 1'b1, 1'b0);

    // Backpressure: A accepted, B stalled while out_ready low, then replaces A.
    cycle(1'b1, 8'hC3, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 3'd2, 1'b0, 1'b0);
    chk("bp_hold_y", 32'(y), 32'h0);
    cycle(1'b1, 8'h5A, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 3'd2, 1'b1, 1'b0);
    chk("bp_second_y", 32'(y), 32'hF);
    cycle(1'b0, '0, 3'd0, 1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_y_kept", 32'(y), 32'hF);

    // Illegal op, sticky error, cleared only by reset.
    cycle(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0);
    chk("ill_y", 32'(y), 32'h0);
    chk("ill_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, pat, 3'(i), 1'b1, 1'b0);
    chk("ill_sticky", 32'(err), 32'd1);
    cycle(1'b0, '0, 3'd0, 1'b1, 1'b1);
    chk("ill_cleared", 32'(err), 32'd0);

    // Saturation: 17 back-to-back accepts into a 4-bit counter.
    for (int i = 0; i < 17; i++) cycle(1'b1, pat, 3'd1, 1'b1, 1'b0);
    chk("sat_count", 32'(count), 32'd15);
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    chk("par_0111", 32'(y_par), 32'd1);
`endif
    cycle(1'b0, '0, 3'd0, 1'b1, 1'b1);

    // Random traffic with occasional illegal ops and resets.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] ro;
      ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), ro,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
